// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and reset values.
package down_counter_timer_pkg;

   // Two-state controller: IDLE holds everything, RUN lets the prescaler drive the count.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Reset values for the single-bit registered controls.
   localparam state_t RST_STATE    = ST_IDLE;
   localparam logic   RST_TC_PULSE = 1'b0;

   // Next controller state after a load: a zero start value has nothing to count.
   function automatic state_t load_state(input logic nonzero);
      return nonzero ? ST_RUN : ST_IDLE;
   endfunction

endpackage

// File: rtl/down_counter_timer_prescaler_tick.sv
// Programmable prescaler: produces a tick once every prescale+1 cycles in which
// run is high. Pausing run freezes the count so the tick phase is preserved.
module prescaler_tick #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] count;

   // Greater-or-equal rather than equality so that shrinking prescale below the
   // current count fires on the next run cycle instead of wrapping around.
   assign tick = run && (count >= prescale);

   // Count run cycles; restart on tick or on an external clear (timer load).
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples
      // the values from before the edge, independent of statement order.
      if (!reset) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable countdown timer with prescaled tick, one-cycle terminal-count pulse
// and optional automatic reload for periodic operation.
module down_counter_timer #(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  enable,
   input  logic                  auto_reload,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      counter_out,
   output logic                  zero,
   output logic                  tc_pulse,
   output logic                  busy
);

   import down_counter_timer_pkg::*;

   localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] reload_reg;
   logic             run;
   logic             tick;

   // The prescaler only advances while running and not paused.
   assign run = (state == ST_RUN) && enable;

   prescaler_tick #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .clear    (load),
      .run      (run),
      .prescale (prescale),
      .tick     (tick)
   );

   // Count state and terminal handling; load overrides any coincident tick.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= RST_STATE;
         counter_out <= '0;
         reload_reg  <= '0;
         tc_pulse    <= RST_TC_PULSE;
      end else if (load) begin
         counter_out <= load_value;
         reload_reg  <= load_value;
         tc_pulse    <= 1'b0;
         state       <= load_state(load_value != '0);
      end else begin
         tc_pulse <= 1'b0;
         if (tick) begin
            // In RUN the count is never zero, so one is the only terminal value.
            if (counter_out != COUNT_ONE) begin
               counter_out <= counter_out - COUNT_ONE;
            end else begin
               tc_pulse <= 1'b1;
               if (auto_reload) begin
                  counter_out <= reload_reg;
               end else begin
                  counter_out <= '0;
                  state       <= ST_IDLE;
               end
            end
         end
      end
   end

   // Status decodes: busy comes straight from the state flop, zero is combinational.
   assign busy = (state == ST_RUN);
   assign zero = (counter_out == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: the driver pushes the hand-computed
// outputs expected after each clock edge; the monitor pops and compares them
// at the following falling edge.
module tb_down_counter_timer;

   logic       clock;
   logic       reset;
   logic       load;
   logic [3:0] load_value;
   logic       enable;
   logic       auto_reload;
   logic [7:0] prescale;
   logic [3:0] counter_out;
   logic       zero;
   logic       tc_pulse;
   logic       busy;

   typedef struct {
      string      tag;
      logic [3:0] cnt;
      logic       tc;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   down_counter_timer #(
      .WIDTH      (4),
      .PRESCALE_W (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .load        (load),
      .load_value  (load_value),
      .enable      (enable),
      .auto_reload (auto_reload),
      .prescale    (prescale),
      .counter_out (counter_out),
      .zero        (zero),
      .tc_pulse    (tc_pulse),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait for the next rising edge, then record what the outputs must be after it.
   task automatic expect_edge(input logic [3:0] c, input logic t, input logic b, input string tag);
      exp_t e;
      @(posedge clock);
      #1;
      e.tag  = tag;
      e.cnt  = c;
      e.tc   = t;
      e.busy = b;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation half a cycle after its edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".count"}, 32'(counter_out), 32'(e.cnt));
            check({e.tag, ".tc"},    32'(tc_pulse),    32'(e.tc));
            check({e.tag, ".busy"},  32'(busy),        32'(e.busy));
            check({e.tag, ".zero"},  32'(zero),        32'(e.cnt == 4'd0));
         end
      end
   end

   initial begin
      reset       = 1'b0;
      load        = 1'b0;
      load_value  = 4'd0;
      enable      = 1'b0;
      auto_reload = 1'b0;
      prescale    = 8'd0;
      repeat (2) @(posedge clock);
      #1;
      check("reset.count", 32'(counter_out), 32'd0);
      check("reset.busy",  32'(busy),        32'd0);
      reset = 1'b1;

      // 1: asynchronous reset in the middle of a run, then stay idle without load.
      load = 1'b1; load_value = 4'd9; enable = 1'b1;
      expect_edge(4'd9, 1'b0, 1'b1, "t1_load");
      load = 1'b0;
      expect_edge(4'd8, 1'b0, 1'b1, "t1_run");
      expect_edge(4'd7, 1'b0, 1'b1, "t1_run");
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("t1_async.count", 32'(counter_out), 32'd0);
      check("t1_async.busy",  32'(busy),        32'd0);
      check("t1_async.tc",    32'(tc_pulse),    32'd0);
      check("t1_async.zero",  32'(zero),        32'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) expect_edge(4'd0, 1'b0, 1'b0, "t1_idle");

      // 2: one-shot countdown from 5 at full rate.
      load = 1'b1; load_value = 4'd5; prescale = 8'd0;
      expect_edge(4'd5, 1'b0, 1'b1, "t2_load");
      load = 1'b0;
      expect_edge(4'd4, 1'b0, 1'b1, "t2_dec");
      expect_edge(4'd3, 1'b0, 1'b1, "t2_dec");
      expect_edge(4'd2, 1'b0, 1'b1, "t2_dec");
      expect_edge(4'd1, 1'b0, 1'b1, "t2_dec");
      expect_edge(4'd0, 1'b1, 1'b0, "t2_tc");
      expect_edge(4'd0, 1'b0, 1'b0, "t2_hold");
      expect_edge(4'd0, 1'b0, 1'b0, "t2_hold");

      // 3: prescale 2 with a four-cycle pause that must not lose the phase.
      load = 1'b1; load_value = 4'd3; prescale = 8'd2;
      expect_edge(4'd3, 1'b0, 1'b1, "t3_load");
      load = 1'b0;
      expect_edge(4'd3, 1'b0, 1'b1, "t3_wait");
      expect_edge(4'd3, 1'b0, 1'b1, "t3_wait");
      expect_edge(4'd2, 1'b0, 1'b1, "t3_tick");
      expect_edge(4'd2, 1'b0, 1'b1, "t3_wait");
      enable = 1'b0;
      for (int i = 0; i < 4; i++) expect_edge(4'd2, 1'b0, 1'b1, "t3_pause");
      enable = 1'b1;
      expect_edge(4'd2, 1'b0, 1'b1, "t3_resume");
      expect_edge(4'd1, 1'b0, 1'b1, "t3_tick");
      expect_edge(4'd1, 1'b0, 1'b1, "t3_wait");
      expect_edge(4'd1, 1'b0, 1'b1, "t3_wait");
      expect_edge(4'd0, 1'b1, 1'b0, "t3_tc");
      expect_edge(4'd0, 1'b0, 1'b0, "t3_hold");

      // 4: periodic reload of 2.
      auto_reload = 1'b1; load = 1'b1; load_value = 4'd2; prescale = 8'd0;
      expect_edge(4'd2, 1'b0, 1'b1, "t4_load");
      load = 1'b0;
      expect_edge(4'd1, 1'b0, 1'b1, "t4_dec");
      expect_edge(4'd2, 1'b1, 1'b1, "t4_reload");
      expect_edge(4'd1, 1'b0, 1'b1, "t4_dec");
      expect_edge(4'd2, 1'b1, 1'b1, "t4_reload");
      expect_edge(4'd1, 1'b0, 1'b1, "t4_dec");

      // 5: load on the terminal-count edge discards the pulse; load 0 goes idle.
      load = 1'b1; load_value = 4'd15;
      expect_edge(4'd15, 1'b0, 1'b1, "t5_load15");
      load_value = 4'd0;
      expect_edge(4'd0, 1'b0, 1'b0, "t5_load0");
      load = 1'b0;
      expect_edge(4'd0, 1'b0, 1'b0, "t5_idle");

      // 6: prescale shrinks from 9 to 1 while the prescaler sits at 5.
      auto_reload = 1'b0; load = 1'b1; load_value = 4'd15; prescale = 8'd9;
      expect_edge(4'd15, 1'b0, 1'b1, "t6_load");
      load = 1'b0;
      for (int i = 0; i < 5; i++) expect_edge(4'd15, 1'b0, 1'b1, "t6_wait");
      prescale = 8'd1;
      expect_edge(4'd14, 1'b0, 1'b1, "t6_shrink");
      expect_edge(4'd14, 1'b0, 1'b1, "t6_wait");
      expect_edge(4'd13, 1'b0, 1'b1, "t6_tick");
      expect_edge(4'd13, 1'b0, 1'b1, "t6_wait");
      expect_edge(4'd12, 1'b0, 1'b1, "t6_tick");

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      #1;
      check("drain.pending", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
